opamp_seq_ctrl: RTL and testbench

//  Digital power-up sequencer and chopper/auto-zero phase generator for the two-stage opamp.

---
 rtl/opamp_seq_ctrl_if.sv | 10 +
 rtl/opamp_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_opamp_seq_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/opamp_seq_ctrl_if.sv
// Byte-wide configuration write port of the opamp sequencer.
// Software side drives it as master; the sequencer samples it as slave.
interface opamp_seq_ctrl_if;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;

  modport master (output cfg_we, cfg_addr, cfg_wdata);
  modport slave  (input  cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/opamp_seq_ctrl.sv
// Power-up sequencer and chopper/auto-zero phase generator for the two-stage opamp.
// Ramps bias -> stage 1 -> stage 2, runs auto-zero, then drives non-overlapping chopper phases.
module opamp_seq_ctrl #(
  parameter int T_BIAS    = 64,
  parameter int T_STG     = 16,
  parameter int AZ_CYCLES = 32,
  parameter int DEAD      = 2,
  parameter int TRIM_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  opamp_seq_ctrl_if.slave   cfg,
  output logic              bias_en,
  output logic              stg1_en,
  output logic              stg2_en,
  output logic              az,
  output logic              phi1,
  output logic              phi2,
  output logic [TRIM_W-1:0] trim,
  output logic              ready
);

  localparam int MAX_BS = (T_BIAS > T_STG) ? T_BIAS : T_STG;
  localparam int MAX_T  = (MAX_BS > AZ_CYCLES) ? MAX_BS : AZ_CYCLES;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  typedef struct packed {
    logic az_req;
    logic chop_en;
    logic enable;
  } ctrl_t;

  typedef enum logic [2:0] {S_OFF, S_BIAS, S_STG1, S_STG2, S_AZ, S_RUN} state_e;
  typedef enum logic [2:0] {C_HOLD, C_P1, C_D1, C_P2, C_D2} chop_e;

  ctrl_t              ctrl_q, ctrl_w, ctrl_d;
  logic [TRIM_W-1:0]  trim_sh_q, trim_w;
  logic [7:0]         div_q, div_w, div_eff;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  chop_e              ch_q, ch_d;
  logic [7:0]         ccnt_q, ccnt_d;
  logic               consume;
  logic               bias_q, stg1_q, stg2_q, az_q, phi1_q, phi2_q, ready_q;
  logic               bias_d, stg1_d, stg2_d, az_d, phi1_d, phi2_d, ready_d;
  logic [TRIM_W-1:0]  trim_q, trim_d;

  // Register values as they will be after this cycle's write; the FSM reacts to them
  // directly so an output changes one clock after the write.
  always_comb begin
    ctrl_w = ctrl_q;
    trim_w = trim_sh_q;
    div_w  = div_q;
    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        2'd0:    ctrl_w = ctrl_t'(cfg.cfg_wdata[2:0]);
        2'd1:    trim_w = cfg.cfg_wdata[TRIM_W-1:0];
        2'd2:    div_w  = cfg.cfg_wdata;
        default: ;
      endcase
    end
    div_eff = (div_w == 8'd0) ? 8'd1 : div_w;
  end

  // Sequencer next state; the counter reloads on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    consume = 1'b0;
    if (!ctrl_w.enable) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_BIAS;
          cnt_d   = CNT_W'(T_BIAS - 1);
        end
        S_BIAS: if (cnt_q == '0) begin
          state_d = S_STG1;
          cnt_d   = CNT_W'(T_STG - 1);
        end
        S_STG1: if (cnt_q == '0) begin
          state_d = S_STG2;
          cnt_d   = CNT_W'(T_STG - 1);
        end
        S_STG2: if (cnt_q == '0) begin
          state_d = S_AZ;
          cnt_d   = CNT_W'(AZ_CYCLES - 1);
        end
        S_AZ: if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
        S_RUN: if (ctrl_w.az_req) begin
          state_d = S_AZ;
          cnt_d   = CNT_W'(AZ_CYCLES - 1);
          consume = 1'b1;
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
    ctrl_d = ctrl_w;
    if (consume) ctrl_d.az_req = 1'b0;
  end

  // Chopper: each phase loads its length when it starts, so DIV writes land at boundaries.
  // HOLD is the static phi1 state used while chopping is disabled.
  always_comb begin
    ch_d   = ch_q;
    ccnt_d = (ccnt_q != 8'd0) ? ccnt_q - 8'd1 : ccnt_q;
    if (state_d != S_RUN) begin
      ch_d   = C_HOLD;
      ccnt_d = 8'd0;
    end else if (state_q != S_RUN) begin
      ch_d   = ctrl_w.chop_en ? C_P1 : C_HOLD;
      ccnt_d = ctrl_w.chop_en ? div_eff - 8'd1 : 8'd0;
    end else begin
      case (ch_q)
        C_HOLD: if (ctrl_w.chop_en) begin
          ch_d   = C_P1;
          ccnt_d = div_eff - 8'd1;
        end
        C_P1: if (ccnt_q == 8'd0) begin
          ch_d   = C_D1;
          ccnt_d = 8'(DEAD - 1);
        end
        C_D1: if (ccnt_q == 8'd0) begin
          ch_d   = ctrl_w.chop_en ? C_P2 : C_HOLD;
          ccnt_d = ctrl_w.chop_en ? div_eff - 8'd1 : 8'd0;
        end
        C_P2: if (ccnt_q == 8'd0) begin
          ch_d   = C_D2;
          ccnt_d = 8'(DEAD - 1);
        end
        C_D2: if (ccnt_q == 8'd0) begin
          ch_d   = ctrl_w.chop_en ? C_P1 : C_HOLD;
          ccnt_d = ctrl_w.chop_en ? div_eff - 8'd1 : 8'd0;
        end
        default: begin
          ch_d   = C_HOLD;
          ccnt_d = 8'd0;
        end
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they change on state entry.
  always_comb begin
    bias_d  = (state_d != S_OFF);
    stg1_d  = (state_d == S_STG1) || (state_d == S_STG2) || (state_d == S_AZ) || (state_d == S_RUN);
    stg2_d  = (state_d == S_STG2) || (state_d == S_AZ) || (state_d == S_RUN);
    az_d    = (state_d == S_AZ);
    ready_d = (state_d == S_RUN);
    phi1_d  = (state_d == S_RUN) && ((ch_d == C_HOLD) || (ch_d == C_P1));
    phi2_d  = (state_d == S_RUN) && (ch_d == C_P2);
    trim_d  = trim_q;
    if ((state_q == S_OFF) || ((state_d == S_AZ) && (state_q != S_AZ)))
      trim_d = trim_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      trim_sh_q <= '0;
      div_q     <= 8'd1;
      state_q   <= S_OFF;
      cnt_q     <= '0;
      ch_q      <= C_HOLD;
      ccnt_q    <= 8'd0;
      bias_q    <= 1'b0;
      stg1_q    <= 1'b0;
      stg2_q    <= 1'b0;
      az_q      <= 1'b0;
      phi1_q    <= 1'b0;
      phi2_q    <= 1'b0;
      ready_q   <= 1'b0;
      trim_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      trim_sh_q <= trim_w;
      div_q     <= div_w;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      ccnt_q    <= ccnt_d;
      bias_q    <= bias_d;
      stg1_q    <= stg1_d;
      stg2_q    <= stg2_d;
      az_q      <= az_d;
      phi1_q    <= phi1_d;
      phi2_q    <= phi2_d;
      ready_q   <= ready_d;
      trim_q    <= trim_d;
    end
  end

  assign bias_en = bias_q;
  assign stg1_en = stg1_q;
  assign stg2_en = stg2_q;
  assign az      = az_q;
  assign phi1    = phi1_q;
  assign phi2    = phi2_q;
  assign ready   = ready_q;
  assign trim    = trim_q;

endmodule

// File: tb/tb_opamp_seq_ctrl.sv
// Directed + randomized bench for opamp_seq_ctrl, checked every cycle against a
// timeline/queue model of the power-up ramp, auto-zero and chopper pattern.
module tb_opamp_seq_ctrl;
  localparam int T_BIAS = 64, T_STG = 16, AZ_CYCLES = 32, DEAD = 2, TRIM_W = 6;
  localparam int T_STG1 = 1 + T_BIAS;          // ramp time at which stg1 turns on
  localparam int T_STG2 = T_STG1 + T_STG;
  localparam int T_AZ   = T_STG2 + T_STG;

  logic clk = 1'b0, rst_n = 1'b0;
  logic bias_en, stg1_en, stg2_en, az, phi1, phi2, ready;
  logic [TRIM_W-1:0] trim;
  opamp_seq_ctrl_if cif();

  opamp_seq_ctrl #(.T_BIAS(T_BIAS), .T_STG(T_STG), .AZ_CYCLES(AZ_CYCLES),
                   .DEAD(DEAD), .TRIM_W(TRIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cif),
    .bias_en(bias_en), .stg1_en(stg1_en), .stg2_en(stg2_en), .az(az),
    .phi1(phi1), .phi2(phi2), .trim(trim), .ready(ready));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  string tag = "init";

  // reference model
  logic m_en, m_chop, m_azr, m_on, m_run;
  logic [TRIM_W-1:0] m_tsh, m_trim;
  logic [7:0] m_div;
  int m_t, m_azl, m_next;
  logic [1:0] m_ph;            // bit0 = phi1, bit1 = phi2
  logic [1:0] cq[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_chop = 0; m_azr = 0; m_on = 0; m_run = 0;
    m_tsh = '0; m_trim = '0; m_div = 8'd1;
    m_t = 0; m_azl = 0; m_next = 1; m_ph = 2'b00; cq.delete();
  endtask

  // Next chopper output: play queued phase pattern, refill at boundaries, else static phi1.
  task automatic chop_next();
    int d;
    if (cq.size() == 0) begin
      if (m_chop) begin
        d = (m_div == 0) ? 1 : int'(m_div);
        for (int i = 0; i < d; i++) cq.push_back(m_next == 1 ? 2'b01 : 2'b10);
        for (int i = 0; i < DEAD; i++) cq.push_back(2'b00);
        m_next = (m_next == 1) ? 2 : 1;
      end else begin
        m_next = 1;
        m_ph = 2'b01;
        return;
      end
    end
    m_ph = cq.pop_front();
  endtask

  task automatic model_step(input logic we, input logic [1:0] a, input logic [7:0] d);
    logic prev_off;
    if (we) begin
      if (a == 2'd0) {m_azr, m_chop, m_en} = d[2:0];
      else if (a == 2'd1) m_tsh = d[TRIM_W-1:0];
      else if (a == 2'd2) m_div = d;
    end
    prev_off = !m_on;
    if (!m_en) begin
      m_on = 0; m_run = 0; m_t = 0; m_azl = 0; m_ph = 2'b00; cq.delete();
    end else if (!m_on) begin
      m_on = 1; m_t = 1;
    end else if (m_t < T_AZ) begin
      m_t++;
      if (m_t == T_AZ) begin m_azl = AZ_CYCLES; m_trim = m_tsh; end
    end else if (m_azl > 1) begin
      m_azl--;
    end else if (m_azl == 1) begin
      m_azl = 0; m_run = 1; m_next = 1; cq.delete(); chop_next();
    end else if (m_azr) begin
      m_azr = 0; m_run = 0; m_azl = AZ_CYCLES; m_trim = m_tsh; m_ph = 2'b00; cq.delete();
    end else begin
      chop_next();
    end
    if (prev_off) m_trim = m_tsh;
  endtask

  function automatic logic [31:0] dut_vec();
    return {19'd0, bias_en, stg1_en, stg2_en, az, phi1, phi2, ready, trim};
  endfunction

  function automatic logic [31:0] mdl_vec();
    return {19'd0, m_on, m_on && (m_t >= T_STG1), m_on && (m_t >= T_STG2), m_azl > 0,
            m_ph[0], m_ph[1], m_run, m_trim};
  endfunction

  task automatic step(input logic we, input logic [1:0] a, input logic [7:0] d);
    cif.cfg_we = we; cif.cfg_addr = a; cif.cfg_wdata = d;
    @(posedge clk);
    model_step(we, a, d);
    cyc++;
    #1;
    chk(tag, dut_vec(), mdl_vec());
    chk("no_overlap", {31'd0, phi1 & phi2}, 32'd0);
    cif.cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, a, d);
  endtask

  // Write CTRL and count cycles until ready, bounded.
  task automatic enable_timed(input logic [7:0] d, output int n);
    wr(2'd0, d);
    n = 1;
    while (!ready && n < 300) begin idle(1); n++; end
  endtask

  int n;
  int r;
  logic [7:0] rd;

  initial begin
    cif.cfg_we = 1'b0; cif.cfg_addr = 2'd0; cif.cfg_wdata = 8'd0;
    model_reset();
    #1;
    tag = "reset";
    chk(tag, dut_vec(), 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    tag = "trim_off";
    wr(2'd1, 8'h15);
    chk("trim_off_follow", {26'd0, trim}, 32'h15);

    tag = "ramp";
    enable_timed(8'h01, n);
    chk("ramp_len", n, 129);
    idle(20);

    tag = "chop_div4";
    wr(2'd2, 8'd4);
    wr(2'd0, 8'h03);
    idle(60);

    tag = "az_req";
    wr(2'd0, 8'h07);
    chk("az_req_az", {31'd0, az}, 32'd1);
    idle(40);

    tag = "trim_run";
    wr(2'd1, 8'h2A);
    idle(3);
    chk("trim_held_in_run", {26'd0, trim}, 32'h15);
    wr(2'd0, 8'h07);
    chk("trim_on_az", {26'd0, trim}, 32'h2A);
    idle(40);

    tag = "div_rand";
    for (int k = 0; k < 6; k++) begin
      wr(2'd2, 8'($urandom_range(0, 5)));
      idle($urandom_range(5, 30));
      wr(2'd0, {6'd0, 1'($urandom_range(0, 1)), 1'b1});
      idle($urandom_range(5, 30));
    end

    tag = "disable";
    wr(2'd0, 8'h00);
    chk("off_all", dut_vec() >> TRIM_W, 32'd0);
    wr(2'd1, 8'h3C);
    chk("trim_off_follow2", {26'd0, trim}, 32'h3C);
    wr(2'd0, 8'h01);
    idle(70);
    wr(2'd0, 8'h00);
    chk("off_stg1", dut_vec() >> TRIM_W, 32'd0);
    idle(3);
    enable_timed(8'h03, n);
    chk("ramp_len2", n, 129);
    idle(10);
    wr(2'd0, 8'h01);
    wr(2'd0, 8'h01);
    idle(10);

    tag = "random";
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rd = {5'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) != 0)};
        wr(2'd0, rd);
      end else if (r < 6) wr(2'd1, 8'($urandom));
      else if (r < 10) wr(2'd2, 8'($urandom_range(0, 6)));
      else if (r < 11) wr(2'd3, 8'($urandom));
      else idle(1);
    end

    tag = "reset_mid_az";
    wr(2'd0, 8'h00);
    wr(2'd0, 8'h01);
    idle(110);
    chk("in_az_before_rst", {31'd0, az}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_vec(), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    tag = "div0";
    wr(2'd2, 8'd0);
    enable_timed(8'h03, n);
    chk("ramp_len3", n, 129);
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
